alu_ctrl_seq: RTL and testbench

Parametrised ALU controller with an integrated multiply/divide sequencer for the MIPS-subset CPU. Single-cycle ops decode `ALUOp_i`/`funct_i` into a 4-bit ALU control code combinationally. `mult`/`div` launch a WIDTH-step iterative sequence that drives an external shift-add/restoring datapath and a HI/LO write. `mfhi`/`mflo` and back-to-back mult/div interlock via `stall_o`. Sits between the main decoder and the ALU / mult-div unit.

---
 rtl/alu_ctrl_pkg.sv | 37 +++
 rtl/md_seq_fsm.sv | 89 ++++++++
 rtl/alu_ctrl_seq.sv | 91 +++++++++
 tb/tb_alu_ctrl_seq.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALUOp/funct/ALUCtrl codes and mult/div sequencer state type
package alu_ctrl_pkg;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_BEQ   = 3'b001;
    localparam logic [2:0] ALUOP_ADDI  = 3'b010;
    localparam logic [2:0] ALUOP_SLTI  = 3'b011;
    localparam logic [2:0] ALUOP_MEM   = 3'b100;
    localparam logic [2:0] ALUOP_JUMP  = 3'b101;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;

    localparam logic [3:0] ALUCTRL_AND = 4'b0000;
    localparam logic [3:0] ALUCTRL_OR  = 4'b0001;
    localparam logic [3:0] ALUCTRL_ADD = 4'b0010;
    localparam logic [3:0] ALUCTRL_SUB = 4'b0110;
    localparam logic [3:0] ALUCTRL_SLT = 4'b0111;
    localparam logic [3:0] ALUCTRL_NOR = 4'b1100;
    localparam logic [3:0] ALUCTRL_NOP = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INIT = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/md_seq_fsm.sv
// rtl/md_seq_fsm.sv - mult/div sequencer: state, step counter, datapath strobes
module md_seq_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic start_div_i,
    output logic md_div_o,
    output logic md_init_o,
    output logic md_step_o,
    output logic hilo_we_o,
    output logic busy_o
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               init_q, init_d;
    logic               step_q, step_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_INIT;
                    div_d   = start_div_i;
                end
            end
            ST_INIT: begin
                state_d = ST_RUN;
                cnt_d   = CNT_W'(WIDTH - 1);
            end
            ST_RUN: begin
                // Counter runs WIDTH-1 down to 0: exactly WIDTH step cycles.
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        init_d = (state_d == ST_INIT);
        step_d = (state_d == ST_RUN);
        we_d   = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            init_q  <= 1'b0;
            step_q  <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            init_q  <= init_d;
            step_q  <= step_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
        end
    end

    assign md_div_o  = div_q;
    assign md_init_o = init_q;
    assign md_step_o = step_q;
    assign hilo_we_o = we_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU control decode with mult/div sequencer; div enabled by ALU_CTRL_DIV_EN
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [2:0] ALUOp_i,
    input  logic [5:0] funct_i,
    output logic [3:0] ALUCtrl_o,
    output logic       illegal_o,
    output logic       md_div_o,
    output logic       md_init_o,
    output logic       md_step_o,
    output logic       hilo_we_o,
    output logic       hilo_sel_o,
    output logic       stall_o,
    output logic       busy_o
);

    logic [3:0] ctrl;
    logic       legal;
    logic       is_mult;
    logic       is_div;
    logic       is_mfhi;
    logic       is_mflo;
    logic       uses_hilo;
    logic       start;

    always_comb begin
        ctrl    = ALUCTRL_NOP;
        legal   = 1'b0;
        is_mult = 1'b0;
        is_div  = 1'b0;
        is_mfhi = 1'b0;
        is_mflo = 1'b0;
        case (ALUOp_i)
            ALUOP_RTYPE: begin
                case (funct_i)
                    FUNCT_ADD: begin ctrl = ALUCTRL_ADD; legal = 1'b1; end
                    FUNCT_SUB: begin ctrl = ALUCTRL_SUB; legal = 1'b1; end
                    FUNCT_AND: begin ctrl = ALUCTRL_AND; legal = 1'b1; end
                    FUNCT_OR:  begin ctrl = ALUCTRL_OR;  legal = 1'b1; end
                    FUNCT_NOR: begin ctrl = ALUCTRL_NOR; legal = 1'b1; end
                    FUNCT_SLT: begin ctrl = ALUCTRL_SLT; legal = 1'b1; end
                    FUNCT_MULT: begin is_mult = 1'b1; legal = 1'b1; end
`ifdef ALU_CTRL_DIV_EN
                    FUNCT_DIV:  begin is_div  = 1'b1; legal = 1'b1; end
`endif
                    FUNCT_MFHI: begin is_mfhi = 1'b1; legal = 1'b1; end
                    FUNCT_MFLO: begin is_mflo = 1'b1; legal = 1'b1; end
                    default: ;
                endcase
            end
            ALUOP_BEQ:  begin ctrl = ALUCTRL_SUB; legal = 1'b1; end
            ALUOP_ADDI: begin ctrl = ALUCTRL_ADD; legal = 1'b1; end
            ALUOP_SLTI: begin ctrl = ALUCTRL_SLT; legal = 1'b1; end
            ALUOP_MEM:  begin ctrl = ALUCTRL_ADD; legal = 1'b1; end
            ALUOP_JUMP: begin ctrl = ALUCTRL_ADD; legal = 1'b1; end
            default: ;
        endcase
    end

    assign ALUCtrl_o  = ctrl;
    assign illegal_o  = valid_i & ~legal;
    assign hilo_sel_o = is_mfhi;

    // Only HI/LO producers and consumers interlock; everything else flows past a running sequence.
    assign uses_hilo = is_mult | is_div | is_mfhi | is_mflo;
    assign stall_o   = valid_i & uses_hilo & busy_o;
    assign start     = valid_i & (is_mult | is_div) & ~stall_o;

    md_seq_fsm #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_md_seq_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start),
        .start_div_i (is_div),
        .md_div_o    (md_div_o),
        .md_init_o   (md_init_o),
        .md_step_o   (md_step_o),
        .hilo_we_o   (hilo_we_o),
        .busy_o      (busy_o)
    );

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed self-checking bench for alu_ctrl_seq (WIDTH=8)
module tb_alu_ctrl_seq;

    localparam int WIDTH = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic [2:0] ALUOp_i;
    logic [5:0] funct_i;
    logic [3:0] ALUCtrl_o;
    logic       illegal_o;
    logic       md_div_o;
    logic       md_init_o;
    logic       md_step_o;
    logic       hilo_we_o;
    logic       hilo_sel_o;
    logic       stall_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    alu_ctrl_seq #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ALUOp_i    (ALUOp_i),
        .funct_i    (funct_i),
        .ALUCtrl_o  (ALUCtrl_o),
        .illegal_o  (illegal_o),
        .md_div_o   (md_div_o),
        .md_init_o  (md_init_o),
        .md_step_o  (md_step_o),
        .hilo_we_o  (hilo_we_o),
        .hilo_sel_o (hilo_sel_o),
        .stall_o    (stall_o),
        .busy_o     (busy_o)
    );

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
        logic       ill;
        logic       sel;
    } vec_t;

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn);
        valid_i = v;
        ALUOp_i = op;
        funct_i = fn;
    endtask

    task automatic apply_reset();
        drive(1'b0, 3'b000, 6'b000000);
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 3'b000, 6'b000000);
        rst_i = 1'b0;
        #2;
        checks++;
        if ({busy_o, md_init_o, md_step_o, hilo_we_o, md_div_o, stall_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {busy_o, md_init_o, md_step_o, hilo_we_o, md_div_o, stall_o});
        end
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_decode();
        vec_t tab[$];
        tab.push_back('{3'b000, 6'b100000, 4'b0010, 1'b0, 1'b0});
        tab.push_back('{3'b000, 6'b100010, 4'b0110, 1'b0, 1'b0});
        tab.push_back('{3'b000, 6'b100100, 4'b0000, 1'b0, 1'b0});
        tab.push_back('{3'b000, 6'b100101, 4'b0001, 1'b0, 1'b0});
        tab.push_back('{3'b000, 6'b100111, 4'b1100, 1'b0, 1'b0});
        tab.push_back('{3'b000, 6'b101010, 4'b0111, 1'b0, 1'b0});
        tab.push_back('{3'b000, 6'b010000, 4'b1111, 1'b0, 1'b1});
        tab.push_back('{3'b000, 6'b010010, 4'b1111, 1'b0, 1'b0});
        tab.push_back('{3'b001, 6'b000011, 4'b0110, 1'b0, 1'b0});
        tab.push_back('{3'b010, 6'b101010, 4'b0010, 1'b0, 1'b0});
        tab.push_back('{3'b011, 6'b100000, 4'b0111, 1'b0, 1'b0});
        tab.push_back('{3'b100, 6'b000000, 4'b0010, 1'b0, 1'b0});
        tab.push_back('{3'b101, 6'b111111, 4'b0010, 1'b0, 1'b0});
        tab.push_back('{3'b000, 6'b000011, 4'b1111, 1'b1, 1'b0});
        tab.push_back('{3'b110, 6'b100000, 4'b1111, 1'b1, 1'b0});
        tab.push_back('{3'b111, 6'b100000, 4'b1111, 1'b1, 1'b0});
        tab.push_back('{3'b000, 6'b011000, 4'b1111, 1'b0, 1'b0});
`ifdef ALU_CTRL_DIV_EN
        tab.push_back('{3'b000, 6'b011010, 4'b1111, 1'b0, 1'b0});
`else
        tab.push_back('{3'b000, 6'b011010, 4'b1111, 1'b1, 1'b0});
`endif
        foreach (tab[i]) begin
            next_cycle();
            drive(1'b1, tab[i].op, tab[i].fn);
            @(negedge clk_i);
            checks++;
            if ({ALUCtrl_o, illegal_o, hilo_sel_o} !== {tab[i].ctrl, tab[i].ill, tab[i].sel}) begin
                errors++;
                $display("FAIL decode[%0d] op=%b fn=%b: got ctrl=%b ill=%b sel=%b expected ctrl=%b ill=%b sel=%b",
                         i, tab[i].op, tab[i].fn, ALUCtrl_o, illegal_o, hilo_sel_o,
                         tab[i].ctrl, tab[i].ill, tab[i].sel);
            end
        end
        next_cycle();
        drive(1'b0, 3'b000, 6'b000011);
        @(negedge clk_i);
        checks++;
        if (illegal_o !== 1'b0) begin
            errors++;
            $display("FAIL decode_invalid_not_illegal: got %b expected 0", illegal_o);
        end
        apply_reset();
    endtask

    task automatic test_mult();
        logic [3:0] exp_v;
        next_cycle();
        drive(1'b1, 3'b000, 6'b011000);
        @(negedge clk_i);
        checks++;
        if ({busy_o, stall_o, ALUCtrl_o} !== {1'b0, 1'b0, 4'b1111}) begin
            errors++;
            $display("FAIL mult_issue: got busy=%b stall=%b ctrl=%b expected 0 0 1111",
                     busy_o, stall_o, ALUCtrl_o);
        end
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            drive(1'b0, 3'b000, 6'b000000);
            @(negedge clk_i);
            exp_v = {(c == 1), (c >= 2 && c <= 9), (c == 10), (c >= 1 && c <= 10)};
            checks++;
            if ({md_init_o, md_step_o, hilo_we_o, busy_o} !== exp_v || md_div_o !== 1'b0) begin
                errors++;
                $display("FAIL mult_profile c%0d: got init/step/we/busy=%b div=%b expected %b div=0",
                         c, {md_init_o, md_step_o, hilo_we_o, busy_o}, md_div_o, exp_v);
            end
        end
    endtask

    task automatic test_mfhi_interlock();
        next_cycle();
        drive(1'b1, 3'b000, 6'b011000);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            drive(1'b0, 3'b000, 6'b000000);
        end
        for (int c = 3; c <= 11; c++) begin
            next_cycle();
            drive(1'b1, 3'b000, 6'b010000);
            @(negedge clk_i);
            checks++;
            if (stall_o !== (c <= 10) || hilo_sel_o !== 1'b1) begin
                errors++;
                $display("FAIL mfhi_stall c%0d: got stall=%b sel=%b expected stall=%b sel=1",
                         c, stall_o, hilo_sel_o, (c <= 10));
            end
        end
        next_cycle();
        drive(1'b0, 3'b000, 6'b000000);
    endtask

    task automatic test_alu_during_run();
        next_cycle();
        drive(1'b1, 3'b000, 6'b011000);
        next_cycle();
        drive(1'b0, 3'b000, 6'b000000);
        for (int c = 2; c <= 4; c++) begin
            next_cycle();
            drive(1'b1, 3'b000, 6'b100000);
            @(negedge clk_i);
            checks++;
            if ({stall_o, ALUCtrl_o, busy_o, md_step_o} !== {1'b0, 4'b0010, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL add_during_run c%0d: got stall=%b ctrl=%b busy=%b step=%b expected 0 0010 1 1",
                         c, stall_o, ALUCtrl_o, busy_o, md_step_o);
            end
        end
        for (int c = 5; c <= 11; c++) begin
            next_cycle();
            drive(1'b0, 3'b000, 6'b000000);
        end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL add_during_run_drain: got busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        drive(1'b1, 3'b000, 6'b011000);
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            drive(1'b0, 3'b000, 6'b000000);
        end
        next_cycle();
        drive(1'b1, 3'b000, 6'b011000);
        @(negedge clk_i);
        checks++;
        if ({stall_o, hilo_we_o} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_done_stall: got stall=%b we=%b expected 1 1", stall_o, hilo_we_o);
        end
        next_cycle();
        @(negedge clk_i);
        checks++;
        if ({stall_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle_issue: got stall=%b busy=%b expected 0 0", stall_o, busy_o);
        end
        next_cycle();
        drive(1'b0, 3'b000, 6'b000000);
        @(negedge clk_i);
        checks++;
        if ({md_init_o, busy_o} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_second_init: got init=%b busy=%b expected 1 1", md_init_o, busy_o);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        drive(1'b1, 3'b000, 6'b011000);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            drive(1'b0, 3'b000, 6'b000000);
        end
        rst_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, md_init_o, md_step_o, hilo_we_o, md_div_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b expected 00000",
                     {busy_o, md_init_o, md_step_o, hilo_we_o, md_div_o});
        end
        next_cycle();
        rst_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            @(negedge clk_i);
            checks++;
            if ({hilo_we_o, busy_o} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_after c%0d: got we=%b busy=%b expected 0 0",
                         c, hilo_we_o, busy_o);
            end
        end
    endtask

    task automatic test_div();
`ifdef ALU_CTRL_DIV_EN
        logic [4:0] exp_v;
        next_cycle();
        drive(1'b1, 3'b000, 6'b011010);
        @(negedge clk_i);
        checks++;
        if ({illegal_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL div_issue: got ill=%b busy=%b expected 0 0", illegal_o, busy_o);
        end
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            drive(1'b0, 3'b000, 6'b000000);
            @(negedge clk_i);
            exp_v = {1'b1, (c == 1), (c >= 2 && c <= 9), (c == 10), 1'b1};
            checks++;
            if ({md_div_o, md_init_o, md_step_o, hilo_we_o, busy_o} !== exp_v) begin
                errors++;
                $display("FAIL div_profile c%0d: got div/init/step/we/busy=%b expected %b",
                         c, {md_div_o, md_init_o, md_step_o, hilo_we_o, busy_o}, exp_v);
            end
        end
        next_cycle();
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL div_end_idle: got busy=%b expected 0", busy_o);
        end
`else
        for (int c = 0; c <= 3; c++) begin
            next_cycle();
            drive(1'b1, 3'b000, 6'b011010);
            @(negedge clk_i);
            checks++;
            if ({illegal_o, ALUCtrl_o, busy_o, stall_o, md_div_o} !== {1'b1, 4'b1111, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL div_disabled c%0d: got ill=%b ctrl=%b busy=%b stall=%b div=%b expected 1 1111 0 0 0",
                         c, illegal_o, ALUCtrl_o, busy_o, stall_o, md_div_o);
            end
        end
        next_cycle();
        drive(1'b0, 3'b000, 6'b000000);
`endif
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 3'b000, 6'b000000);
        test_reset();
        test_decode();
        test_mult();
        test_mfhi_interlock();
        test_alu_during_run();
        test_back_to_back();
        test_reset_mid();
        test_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
